// File: rtl/cmp_window_monitor_pkg.sv
// Shared types and helpers for the comparator window monitor.
// The package name is cmp_mon_pkg.
// Optional feature macro: CMP_MON_ONEHOT_CHECK_EN (one-hot flag checking).
package cmp_mon_pkg;

  typedef enum logic [1:0] {S_IDLE, S_GT, S_LT, S_EQ} streak_state_t;
  typedef enum logic [1:0] {CLS_NONE, CLS_GT, CLS_LT, CLS_EQ} cmp_cls_t;

  // Priority classification: gt beats lt beats et; an all-zero triple is EQ.
  function automatic cmp_cls_t classify(input logic gt, input logic lt, input logic et);
    if (gt)      return CLS_GT;
    else if (lt) return CLS_LT;
    else if (et) return CLS_EQ;
    else         return CLS_EQ;
  endfunction

  // True when exactly one of the three flags is set.
  function automatic logic is_onehot(input logic gt, input logic lt, input logic et);
    return ({gt, lt, et} == 3'b100) || ({gt, lt, et} == 3'b010) ||
           ({gt, lt, et} == 3'b001);
  endfunction

  // Maps a result class onto the streak state that tracks it.
  function automatic streak_state_t cls_to_state(input cmp_cls_t c);
    case (c)
      CLS_GT:  return S_GT;
      CLS_LT:  return S_LT;
      CLS_EQ:  return S_EQ;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cmp_window_monitor_streak_fsm.sv
// Streak tracker: follows the class of the current run of identical results
// and pulses streak_hit once when a run reaches STREAK_LEN samples.
// The state register is exported directly as streak_cls, so the state
// encoding (S_GT=1, S_LT=2, S_EQ=3) doubles as the visible class code.
module cmp_streak_fsm
  import cmp_mon_pkg::*;
#(
  parameter int STREAK_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       acc,
  input  cmp_cls_t   cls,
  output logic       streak_hit,
  output logic [1:0] streak_cls
);

  localparam int RUN_W = $clog2(STREAK_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STREAK_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  streak_state_t    state;
  streak_state_t    cls_state;
  logic [RUN_W-1:0] run;

  assign cls_state  = cls_to_state(cls);
  assign streak_cls = state;

  // Run tracking: same class extends the run (saturating), a new class restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      run        <= '0;
      streak_hit <= 1'b0;
    end else begin
      streak_hit <= 1'b0;
      if (acc) begin
        if (state == cls_state) begin
          if (run != RUN_MAX) begin
            run        <= run + RUN_ONE;
            streak_hit <= (run == RUN_MAX - RUN_ONE);
          end
        end else begin
          state <= cls_state;
          run   <= RUN_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/cmp_window_monitor.sv
// Window monitor for comparator gt/lt/et flags: tallies WINDOW accepted
// samples and presents the three counts as one summary, plus a streak pulse.
// Optional macro CMP_MON_ONEHOT_CHECK_EN rejects triples that are not one-hot
// (accepted but not counted) and pulses flag_err for them.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid, once raised, holds (with its data stable) until that
// edge. Here in_ready = !out_valid, so input stalls while a summary waits.
module cmp_window_monitor
  import cmp_mon_pkg::*;
#(
  parameter int WINDOW     = 8,
  parameter int STREAK_LEN = 3,
  parameter int CNT_W      = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             gt,
  input  logic             lt,
  input  logic             et,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic             streak_hit,
  output logic [1:0]       streak_cls,
  output logic             flag_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic             acc;
  logic             legal;
  logic             cnt_acc;
  cmp_cls_t         cls;
  logic [CNT_W-1:0] smp;
  logic [CNT_W-1:0] gt_acc, lt_acc, eq_acc;
  logic [CNT_W-1:0] gt_nxt, lt_nxt, eq_nxt;

  assign in_ready = !out_valid;
  assign acc      = in_valid && in_ready;
  assign cls      = classify(gt, lt, et);

`ifdef CMP_MON_ONEHOT_CHECK_EN
  assign legal = is_onehot(gt, lt, et);

  // Registered pulse for a handshake that carried an illegal triple.
  always_ff @(posedge clk) begin
    if (rst) flag_err <= 1'b0;
    else     flag_err <= acc && !legal;
  end
`else
  assign legal    = 1'b1;
  assign flag_err = 1'b0;
`endif

  assign cnt_acc = acc && legal;

  // Tallies including the sample being accepted this cycle.
  always_comb begin
    gt_nxt = gt_acc;
    lt_nxt = lt_acc;
    eq_nxt = eq_acc;
    case (cls)
      CLS_GT:  gt_nxt = gt_acc + ONE;
      CLS_LT:  lt_nxt = lt_acc + ONE;
      CLS_EQ:  eq_nxt = eq_acc + ONE;
      default: ;
    endcase
  end

  // Window accumulation, summary load on the last sample, output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      smp       <= '0;
      gt_acc    <= '0;
      lt_acc    <= '0;
      eq_acc    <= '0;
      gt_cnt    <= '0;
      lt_cnt    <= '0;
      eq_cnt    <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (cnt_acc) begin
        if (smp == LAST) begin
          gt_cnt    <= gt_nxt;
          lt_cnt    <= lt_nxt;
          eq_cnt    <= eq_nxt;
          out_valid <= 1'b1;
          smp       <= '0;
          gt_acc    <= '0;
          lt_acc    <= '0;
          eq_acc    <= '0;
        end else begin
          smp    <= smp + ONE;
          gt_acc <= gt_nxt;
          lt_acc <= lt_nxt;
          eq_acc <= eq_nxt;
        end
      end
    end
  end

  cmp_streak_fsm #(
    .STREAK_LEN(STREAK_LEN)
  ) u_streak (
    .clk       (clk),
    .rst       (rst),
    .acc       (cnt_acc),
    .cls       (cls),
    .streak_hit(streak_hit),
    .streak_cls(streak_cls)
  );

endmodule

// File: doc/cmp_window_monitor.md
# cmp_window_monitor

Downstream consumer of the 2-bit magnitude comparator's `gt`/`lt`/`et` flags. It accepts one flag triple per valid/ready handshake and tallies results over a fixed window of `WINDOW` samples. At the end of each window it emits a summary over a valid/ready output. In parallel it runs a streak FSM that pulses when the same result class repeats `STREAK_LEN` times in a row.

## Interface
Parameters:
- `WINDOW`, default 8: samples per summary, ≥2.
- `STREAK_LEN`, default 3: consecutive identical results that fire `streak_hit`, ≥2.
- `CNT_W`, default `$clog2(WINDOW+1)`: counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  flag triple present.
- `in_ready`  out  1  block can accept.
- `gt`, `lt`, `et`  in  1 each  comparator flags.
- `out_valid`  out  1  summary valid.
- `out_ready`  in  1  summary consumer ready.
- `gt_cnt`, `lt_cnt`, `eq_cnt`  out  CNT_W each  window tallies, stable while `out_valid`.
- `streak_hit`  out  1  one-cycle pulse.
- `streak_cls`  out  2  class of the current run: 0 none, 1 GT, 2 LT, 3 EQ.
- `flag_err`  out  1  one-cycle pulse on an illegal triple (only with the macro).

## Operation
- Accept occurs when `in_valid && in_ready`. `in_ready = !out_valid`, so no input is accepted while a summary is pending.
- Classification, per the Configuration section: GT, LT or EQ increments the matching internal counter. Sample counter `smp` counts 0..WINDOW-1.
- On the accept that completes a window (`smp == WINDOW-1`):
  - the counts, including that sample, are loaded into the output registers;
  - `out_valid` is set;
  - the internal counters and `smp` clear on the same edge.
- `out_valid` clears on the edge where `out_valid && out_ready`. Output counts hold their value until the next load.
- Invariant: `gt_cnt + lt_cnt + eq_cnt == WINDOW` at every `out_valid`.
- Streak FSM (states `S_IDLE`, `S_GT`, `S_LT`, `S_EQ`) plus a run counter `run` saturating at STREAK_LEN:
  - `S_IDLE` → class state on the first accepted sample, with `run=1`.
  - Same class: `run` increments, saturating.
  - Different class: move to the new class state with `run=1`.
  - `streak_hit` pulses only on the accept where `run` goes from STREAK_LEN-1 to STREAK_LEN. It fires once per run; re-arm requires a class change.
  - Streaks carry across window boundaries. Stalls from `in_ready=0` do not break a run.
- `streak_cls` reflects the FSM state: 0 in `S_IDLE`.

## Timing
- Reset values:
  - `out_valid`=0, `in_ready`=1;
  - all counts 0, `smp`=0;
  - FSM in `S_IDLE`, `run`=0, `streak_cls`=0;
  - `streak_hit`=0, `flag_err`=0.
- Reset mid-window or with `out_valid` high discards everything. `out_valid` drops the cycle after `rst` is sampled high.
- Latency:
  - `out_valid` rises 1 cycle after the completing accept.
  - `streak_hit` and `flag_err` are registered and pulse 1 cycle after the triggering accept.
- Earliest next accept is the cycle after the output handshake. For back-to-back windows, one idle cycle per window is the minimum.
- `out_valid` must not drop and the output counts must not change until the handshake completes.
- `in_valid` held with `in_ready=0` causes no state change.

## Configuration
- Macro `CMP_MON_ONEHOT_CHECK_EN`.
- Defined:
  - A triple that is not exactly one-hot is rejected: it is still accepted (handshake completes) but not counted, `smp` and the FSM are untouched, and `flag_err` pulses.
- Undefined:
  - No checking; priority `gt` > `lt` > `et`.
  - All-zero counts as EQ.
  - `flag_err` is tied 0.

## Structure
- Package `cmp_mon_pkg`:
  - `typedef enum logic [1:0] {S_IDLE, S_GT, S_LT, S_EQ} streak_state_t`;
  - `typedef enum logic [1:0] {CLS_NONE, CLS_GT, CLS_LT, CLS_EQ} cmp_cls_t`;
  - classification function.
- One sub-module, `cmp_streak_fsm`, containing the FSM, `run` and `streak_hit`. It takes the accept strobe and the class.
- The top holds the window counters, the output registers and the handshake.

## Test plan
All scenarios use WINDOW=4, STREAK_LEN=3 unless noted.
- Reset then triples GT, GT, LT, EQ with `out_ready=1` → `out_valid` 1 cycle after the 4th accept; `gt_cnt`=2, `lt_cnt`=1, `eq_cnt`=1; `in_ready`=0 for exactly that cycle.
- Hold `out_ready=0` for 5 cycles after a window while `in_valid=1` → `in_ready` stays 0, counts stable, no samples lost. After the handshake the next window counts from 0.
- EQ×5 → `streak_hit` fires once, 1 cycle after the 3rd EQ. Then LT×3 → a second `streak_hit`; `streak_cls`=2.
- A streak straddling a window boundary (GT at samples 3, 4, 5 with a stall between) → `streak_hit` after sample 5.
- With the macro: triple gt=1, lt=1 → `flag_err` pulse, counts and `smp` unchanged. Without the macro: the same triple counts as GT.
- Assert `rst` after 2 accepts and while `out_valid`=1 → all outputs return to reset values the next cycle. A following window reports only post-reset samples.
